// File: rtl/multi_rotary_tracker_if.sv
`default_nettype none
//==============================================================================
// Module   : multi_rotary_tracker_if
// Brief    : Pin, control and position bundle for multi_rotary_tracker.
// Revision : 1.0 - initial release
//==============================================================================
interface multi_rotary_tracker_if #(
    parameter int N_PLAYERS = 2,
    parameter int POS_W     = 16
);
    logic [N_PLAYERS-1:0]       x_a;
    logic [N_PLAYERS-1:0]       x_b;
    logic [N_PLAYERS-1:0]       y_a;
    logic [N_PLAYERS-1:0]       y_b;
    logic [N_PLAYERS-1:0]       recenter;
    logic                       freeze;
    logic [N_PLAYERS*POS_W-1:0] pos_x;
    logic [N_PLAYERS*POS_W-1:0] pos_y;
    logic [N_PLAYERS-1:0]       moved;
    logic [2*N_PLAYERS-1:0]     at_limit;
    logic [2*N_PLAYERS-1:0]     quad_err;

    modport master (
        output x_a, x_b, y_a, y_b, recenter, freeze,
        input  pos_x, pos_y, moved, at_limit, quad_err
    );

    modport slave (
        input  x_a, x_b, y_a, y_b, recenter, freeze,
        output pos_x, pos_y, moved, at_limit, quad_err
    );
endinterface
`default_nettype wire

// File: rtl/multi_rotary_tracker.sv
`default_nettype none
//==============================================================================
// Module   : multi_rotary_tracker
// Brief    : Per-player X/Y quadrature decoders with synchronisers, debounce
//            and saturating position registers.
// Revision : 1.0 - initial release
//==============================================================================
module multi_rotary_tracker #(
    parameter int N_PLAYERS   = 2,
    parameter int POS_W       = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int STEP        = 4,
    parameter int DEB_CYCLES  = 1000,
    parameter int QUAD_MODE   = 0,
    parameter int RST_BASE    = 100,
    parameter int RST_SPACING = 300
) (
    input  wire logic              clk,
    input  wire logic              reset,
    multi_rotary_tracker_if.slave  trk
);

    localparam int                 c_npins    = 4 * N_PLAYERS;
    localparam int                 c_cnt_w    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [POS_W:0]     c_step     = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0]   c_xmin     = POS_W'(X_MIN);
    localparam logic [POS_W-1:0]   c_xmax     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]   c_ymin     = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0]   c_ymax     = POS_W'(Y_MAX);

    // Pin k of player p sits at 4p+k: 0 = x_a, 1 = x_b, 2 = y_a, 3 = y_b
    logic [c_npins-1:0] w_raw;
    logic [c_npins-1:0] w_deb;

    // Returns {illegal, minus_one, plus_one} for a {A,B} state transition
    function automatic logic [2:0] decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        if (QUAD_MODE == 0) begin
            if (!prev[1] && cur[1]) begin
                res = cur[0] ? 3'b010 : 3'b001;
            end
        end else begin
            case ({prev, cur})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: res = 3'b001;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: res = 3'b010;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: res = 3'b100;
                default:                            res = 3'b000;
            endcase
        end
        return res;
    endfunction

    // One extra bit keeps both overflow above MAX and underflow below zero visible
    function automatic logic [POS_W-1:0] step_pos(
        input logic [POS_W-1:0] pos,
        input logic             up,
        input logic             dn,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic [POS_W:0]   sum;
        logic [POS_W-1:0] res;
        sum = '0;
        res = pos;
        if (up) begin
            sum = {1'b0, pos} + c_step;
            res = (sum > {1'b0, hi}) ? hi : sum[POS_W-1:0];
        end else if (dn) begin
            sum = {1'b0, pos} - c_step;
            res = (sum[POS_W] || (sum < {1'b0, lo})) ? lo : sum[POS_W-1:0];
        end
        return res;
    endfunction

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_pack
        assign w_raw[4*i +: 4] = {trk.y_b[i], trk.y_a[i], trk.x_b[i], trk.x_a[i]};
    end

    for (genvar g = 0; g < c_npins; g++) begin : g_pin
        logic               r_s1;
        logic               r_s2;
        logic               r_deb;
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_deb <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign w_deb[g] = r_deb;
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        localparam logic [POS_W-1:0] c_rst_pos = POS_W'(RST_BASE + p * RST_SPACING);

        logic [1:0]       r_xprev;
        logic [1:0]       r_yprev;
        logic [1:0]       w_xcur;
        logic [1:0]       w_ycur;
        logic [2:0]       w_xdec;
        logic [2:0]       w_ydec;
        logic [POS_W-1:0] r_px;
        logic [POS_W-1:0] r_py;
        logic [POS_W-1:0] w_nx;
        logic [POS_W-1:0] w_ny;
        logic             r_moved;
        logic [1:0]       r_qerr;

        assign w_xcur = {w_deb[4*p],     w_deb[4*p + 1]};
        assign w_ycur = {w_deb[4*p + 2], w_deb[4*p + 3]};
        assign w_xdec = decode(r_xprev, w_xcur);
        assign w_ydec = decode(r_yprev, w_ycur);

        // Counts seen while frozen are simply dropped, never deferred
        always_comb begin
            w_nx = r_px;
            w_ny = r_py;
            if (trk.recenter[p]) begin
                w_nx = c_rst_pos;
                w_ny = c_rst_pos;
            end else if (!trk.freeze) begin
                w_nx = step_pos(r_px, w_xdec[0], w_xdec[1], c_xmin, c_xmax);
                w_ny = step_pos(r_py, w_ydec[0], w_ydec[1], c_ymin, c_ymax);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_xprev <= 2'b00;
                r_yprev <= 2'b00;
                r_px    <= c_rst_pos;
                r_py    <= c_rst_pos;
                r_moved <= 1'b0;
                r_qerr  <= 2'b00;
            end else begin
                r_xprev <= w_xcur;
                r_yprev <= w_ycur;
                r_px    <= w_nx;
                r_py    <= w_ny;
                r_moved <= (w_nx != r_px) || (w_ny != r_py);
                if (trk.recenter[p]) begin
                    r_qerr <= 2'b00;
                end else begin
                    r_qerr <= r_qerr | {w_ydec[2], w_xdec[2]};
                end
            end
        end

        assign trk.pos_x[p*POS_W +: POS_W] = r_px;
        assign trk.pos_y[p*POS_W +: POS_W] = r_py;
        assign trk.moved[p]                = r_moved;
        assign trk.at_limit[2*p]           = (r_px == c_xmin) || (r_px == c_xmax);
        assign trk.at_limit[2*p + 1]       = (r_py == c_ymin) || (r_py == c_ymax);
        assign trk.quad_err[2*p +: 2]      = r_qerr;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_rotary_tracker.sv
`default_nettype none
//==============================================================================
// Module   : tb_multi_rotary_tracker
// Brief    : Self-checking bench; one x1-decode and one x4-decode instance.
// Revision : 1.0 - initial release
//==============================================================================
module tb_multi_rotary_tracker;

    localparam int c_np  = 2;
    localparam int c_pw  = 16;
    localparam int c_deb = 4;
    localparam int c_lat = c_deb + 3;
    localparam int c_win = c_deb + 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   q_exp[$];
    int   model0 [2][2];   // [axis][player] for the x1 instance
    int   model1 [2][2];   // [axis][player] for the x4 instance

    multi_rotary_tracker_if #(.N_PLAYERS(c_np), .POS_W(c_pw)) bus0 ();
    multi_rotary_tracker_if #(.N_PLAYERS(c_np), .POS_W(c_pw)) bus1 ();

    multi_rotary_tracker #(
        .N_PLAYERS(c_np), .POS_W(c_pw), .DEB_CYCLES(c_deb), .QUAD_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .trk(bus0)
    );

    multi_rotary_tracker #(
        .N_PLAYERS(c_np), .POS_W(c_pw), .DEB_CYCLES(c_deb), .QUAD_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .trk(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1, "watchdog");
    end

    function automatic int get_pos(input int d, input int ax, input int p);
        logic [c_pw-1:0] v;
        if (d == 0) v = (ax == 0) ? bus0.pos_x[p*c_pw +: c_pw] : bus0.pos_y[p*c_pw +: c_pw];
        else        v = (ax == 0) ? bus1.pos_x[p*c_pw +: c_pw] : bus1.pos_y[p*c_pw +: c_pw];
        return int'(v);
    endfunction

    function automatic logic get_moved(input int d, input int p);
        return (d == 0) ? bus0.moved[p] : bus1.moved[p];
    endfunction

    function automatic logic [3:0] get_lim(input int d);
        return (d == 0) ? bus0.at_limit : bus1.at_limit;
    endfunction

    function automatic logic [3:0] get_qerr(input int d);
        return (d == 0) ? bus0.quad_err : bus1.quad_err;
    endfunction

    function automatic int sat_step(input int cur, input int dir, input int hi);
        int v;
        v = cur + 4 * dir;
        if (v > hi) v = hi;
        if (v < 0)  v = 0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pin(input int d, input int ax, input int p, input bit is_b, input logic v);
        if (d == 0) begin
            if (ax == 0) begin
                if (is_b) bus0.x_b[p] = v; else bus0.x_a[p] = v;
            end else begin
                if (is_b) bus0.y_b[p] = v; else bus0.y_a[p] = v;
            end
        end else begin
            if (ax == 0) begin
                if (is_b) bus1.x_b[p] = v; else bus1.x_a[p] = v;
            end else begin
                if (is_b) bus1.y_b[p] = v; else bus1.y_a[p] = v;
            end
        end
    endtask

    // x1 count on the QUAD_MODE=0 instance: settle B, raise A, watch for moved, drop A
    task automatic x1_count(input int ax, input int p, input int dir, input bit frz,
                            output bit exp_move, output bit seen, output int lat, output int obs);
        int nv;
        set_pin(0, ax, p, 1'b1, (dir < 0));
        repeat (c_deb + 4) tick();
        nv = frz ? model0[ax][p] : sat_step(model0[ax][p], dir, (ax == 0) ? 639 : 479);
        exp_move = (nv != model0[ax][p]);
        if (exp_move) q_exp.push_back(nv);
        model0[ax][p] = nv;
        set_pin(0, ax, p, 1'b0, 1'b1);
        seen = 1'b0;
        lat  = 0;
        obs  = 0;
        for (int k = 1; k <= c_win; k++) begin
            tick();
            if (!seen && get_moved(0, p)) begin
                seen = 1'b1;
                lat  = k;
                obs  = get_pos(0, ax, p);
            end
        end
        set_pin(0, ax, p, 1'b0, 1'b0);
        repeat (c_deb + 4) tick();
    endtask

    // Gray-state move on the QUAD_MODE=1 instance; both pins change together
    task automatic gray_move(input int ax, input int p, input logic a, input logic b,
                             output bit seen, output int lat, output int obs);
        set_pin(1, ax, p, 1'b0, a);
        set_pin(1, ax, p, 1'b1, b);
        seen = 1'b0;
        lat  = 0;
        obs  = 0;
        for (int k = 1; k <= c_win; k++) begin
            tick();
            if (!seen && get_moved(1, p)) begin
                seen = 1'b1;
                lat  = k;
                obs  = get_pos(1, ax, p);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        bus0.x_a = '0; bus0.x_b = '0; bus0.y_a = '0; bus0.y_b = '0;
        bus1.x_a = '0; bus1.x_b = '0; bus1.y_a = '0; bus1.y_b = '0;
        bus0.recenter = '0; bus1.recenter = '0;
        bus0.freeze = 1'b0; bus1.freeze = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < c_np; p++) begin
                checks++;
                if (get_pos(d, 0, p) !== 100 + 300 * p || get_pos(d, 1, p) !== 100 + 300 * p) begin
                    errors++;
                    $display("FAIL reset_pos d%0d p%0d: got %0d/%0d, expected %0d", d, p,
                             get_pos(d, 0, p), get_pos(d, 1, p), 100 + 300 * p);
                end
            end
            checks++;
            if (get_qerr(d) !== 4'b0000 || (d == 0 ? bus0.moved : bus1.moved) !== 2'b00) begin
                errors++;
                $display("FAIL reset_flags d%0d: quad_err=%b, expected 0000 and moved=0", d, get_qerr(d));
            end
        end
        reset = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < c_np; p++) begin
                model0[0][p] = 100 + 300 * p;
                model0[1][p] = 100 + 300 * p;
                model1[0][p] = 100 + 300 * p;
                model1[1][p] = 100 + 300 * p;
                checks++;
                if (get_pos(d, 0, p) !== 100 + 300 * p || get_pos(d, 1, p) !== 100 + 300 * p ||
                    get_moved(d, p) !== 1'b0) begin
                    errors++;
                    $display("FAIL release_pos d%0d p%0d: got %0d/%0d moved=%b, expected %0d moved=0",
                             d, p, get_pos(d, 0, p), get_pos(d, 1, p), get_moved(d, p), 100 + 300 * p);
                end
            end
            checks++;
            if (get_lim(d) !== 4'b0000) begin
                errors++;
                $display("FAIL release_limit d%0d: got %b, expected 0000", d, get_lim(d));
            end
        end
    endtask

    task automatic test_x1_latency();
        int e;
        int old;
        bit any;
        old = model0[0][0];
        set_pin(0, 0, 0, 1'b1, 1'b0);
        repeat (c_deb + 4) tick();
        model0[0][0] = sat_step(old, 1, 639);
        q_exp.push_back(model0[0][0]);
        set_pin(0, 0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= c_lat + 1; k++) begin
            tick();
            if (k == c_lat - 1) begin
                checks++;
                if (get_pos(0, 0, 0) !== old || get_moved(0, 0) !== 1'b0) begin
                    errors++;
                    $display("FAIL early_update: edge %0d pos=%0d moved=%b, expected %0d moved=0",
                             k, get_pos(0, 0, 0), get_moved(0, 0), old);
                end
            end else if (k == c_lat) begin
                e = q_exp.pop_front();
                checks++;
                if (get_pos(0, 0, 0) !== e || get_moved(0, 0) !== 1'b1) begin
                    errors++;
                    $display("FAIL x1_latency: edge %0d pos=%0d moved=%b, expected %0d moved=1",
                             k, get_pos(0, 0, 0), get_moved(0, 0), e);
                end
            end else if (k == c_lat + 1) begin
                checks++;
                if (get_moved(0, 0) !== 1'b0) begin
                    errors++;
                    $display("FAIL moved_width: moved=%b one cycle later, expected 0", get_moved(0, 0));
                end
            end
        end
        set_pin(0, 0, 0, 1'b0, 1'b0);
        any = 1'b0;
        for (int k = 0; k < c_win; k++) begin
            tick();
            any |= get_moved(0, 0);
        end
        checks++;
        if (any || get_pos(0, 0, 0) !== model0[0][0]) begin
            errors++;
            $display("FAIL a_falling: moved=%b pos=%0d, expected no move pos=%0d",
                     any, get_pos(0, 0, 0), model0[0][0]);
        end
    endtask

    task automatic test_glitch();
        bit any;
        bit em;
        bit seen;
        int lat;
        int obs;
        int e;
        set_pin(0, 0, 0, 1'b0, 1'b1);
        repeat (3) tick();
        set_pin(0, 0, 0, 1'b0, 1'b0);
        any = 1'b0;
        for (int k = 0; k < c_win + 4; k++) begin
            tick();
            any |= get_moved(0, 0);
        end
        checks++;
        if (any || get_pos(0, 0, 0) !== model0[0][0]) begin
            errors++;
            $display("FAIL glitch: moved=%b pos=%0d, expected no move pos=%0d",
                     any, get_pos(0, 0, 0), model0[0][0]);
        end
        // A full debounce window after the glitch proves the counter restarted from zero
        x1_count(0, 0, 1, 1'b0, em, seen, lat, obs);
        checks++;
        e = em ? q_exp.pop_front() : -1;
        if (!em || !seen || obs !== e || lat !== c_lat) begin
            errors++;
            $display("FAIL post_glitch: seen=%b pos=%0d lat=%0d, expected pos=%0d lat=%0d",
                     seen, obs, lat, e, c_lat);
        end
    endtask

    task automatic test_saturation();
        bit em;
        bit seen;
        int lat;
        int obs;
        int e;
        logic [3:0] lim;
        for (int n = 1; n <= 21; n++) begin
            x1_count(1, 1, 1, 1'b0, em, seen, lat, obs);
            checks++;
            if (em) begin
                e = q_exp.pop_front();
                if (!seen || obs !== e || lat !== c_lat) begin
                    errors++;
                    $display("FAIL y1_up count %0d: seen=%b pos=%0d lat=%0d, expected pos=%0d lat=%0d",
                             n, seen, obs, lat, e, c_lat);
                end
            end else if (seen || get_pos(0, 1, 1) !== model0[1][1]) begin
                errors++;
                $display("FAIL y1_saturated count %0d: moved=%b pos=%0d, expected no move pos=%0d",
                         n, seen, get_pos(0, 1, 1), model0[1][1]);
            end
        end
        lim = get_lim(0);
        checks++;
        if (lim[3] !== 1'b1 || get_pos(0, 1, 1) !== 479) begin
            errors++;
            $display("FAIL y1_limit: at_limit=%b pos=%0d, expected bit3=1 pos=479", lim, get_pos(0, 1, 1));
        end
        x1_count(1, 1, -1, 1'b0, em, seen, lat, obs);
        e = em ? q_exp.pop_front() : -1;
        lim = get_lim(0);
        checks++;
        if (!seen || obs !== e || lim[3] !== 1'b0) begin
            errors++;
            $display("FAIL y1_down: seen=%b pos=%0d at_limit=%b, expected pos=%0d bit3=0", seen, obs, lim, e);
        end
        for (int n = 1; n <= 28; n++) begin
            x1_count(0, 0, -1, 1'b0, em, seen, lat, obs);
            checks++;
            if (em) begin
                e = q_exp.pop_front();
                if (!seen || obs !== e) begin
                    errors++;
                    $display("FAIL x0_down count %0d: seen=%b pos=%0d, expected pos=%0d", n, seen, obs, e);
                end
            end else if (seen || get_pos(0, 0, 0) !== model0[0][0]) begin
                errors++;
                $display("FAIL x0_floor count %0d: moved=%b pos=%0d, expected no move pos=%0d",
                         n, seen, get_pos(0, 0, 0), model0[0][0]);
            end
        end
        lim = get_lim(0);
        checks++;
        if (lim[0] !== 1'b1 || get_pos(0, 0, 0) !== 0) begin
            errors++;
            $display("FAIL x0_limit: at_limit=%b pos=%0d, expected bit0=1 pos=0", lim, get_pos(0, 0, 0));
        end
    endtask

    task automatic test_freeze();
        bit em;
        bit seen;
        int lat;
        int obs;
        bus0.freeze = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            x1_count(0, 0, 1, 1'b1, em, seen, lat, obs);
            checks++;
            if (em || seen) begin
                errors++;
                $display("FAIL frozen count %0d: moved=%b pos=%0d, expected no move pos=%0d",
                         n, seen, obs, model0[0][0]);
            end
        end
        bus0.freeze = 1'b0;
        repeat (c_win) tick();
        checks++;
        if (get_pos(0, 0, 0) !== model0[0][0] || get_pos(0, 1, 0) !== model0[1][0]) begin
            errors++;
            $display("FAIL unfreeze: pos=%0d/%0d, expected %0d/%0d",
                     get_pos(0, 0, 0), get_pos(0, 1, 0), model0[0][0], model0[1][0]);
        end
    endtask

    task automatic test_recenter_priority();
        set_pin(0, 0, 0, 1'b1, 1'b0);
        repeat (c_deb + 4) tick();
        set_pin(0, 0, 0, 1'b0, 1'b1);
        repeat (c_lat - 1) tick();
        bus0.recenter[0] = 1'b1;
        tick();
        bus0.recenter[0] = 1'b0;
        model0[0][0] = 100;
        model0[1][0] = 100;
        checks++;
        if (get_pos(0, 0, 0) !== 100 || get_pos(0, 1, 0) !== 100 || get_moved(0, 0) !== 1'b1) begin
            errors++;
            $display("FAIL recenter_vs_count: pos=%0d/%0d moved=%b, expected 100/100 moved=1",
                     get_pos(0, 0, 0), get_pos(0, 1, 0), get_moved(0, 0));
        end
        repeat (c_win) tick();
        checks++;
        if (get_pos(0, 0, 0) !== 100) begin
            errors++;
            $display("FAIL recenter_hold: pos=%0d, expected 100", get_pos(0, 0, 0));
        end
        set_pin(0, 0, 0, 1'b0, 1'b0);
        repeat (c_deb + 4) tick();
    endtask

    task automatic test_quad();
        logic sa [3] = '{1'b0, 1'b1, 1'b0};
        logic sb [3] = '{1'b1, 1'b1, 1'b1};
        int   sd [3] = '{1, 1, -1};
        bit seen;
        int lat;
        int obs;
        int ox;
        int oy;
        int e;
        int ey;
        logic [3:0] qe;
        for (int i = 0; i < 3; i++) begin
            model1[0][0] = sat_step(model1[0][0], sd[i], 639);
            q_exp.push_back(model1[0][0]);
            gray_move(0, 0, sa[i], sb[i], seen, lat, obs);
            e = q_exp.pop_front();
            checks++;
            if (!seen || obs !== e || lat !== c_lat) begin
                errors++;
                $display("FAIL x4_step %0d: seen=%b pos=%0d lat=%0d, expected pos=%0d lat=%0d",
                         i, seen, obs, lat, e, c_lat);
            end
        end
        gray_move(1, 0, 1'b1, 1'b1, seen, lat, obs);
        qe = get_qerr(1);
        checks++;
        if (seen || get_pos(1, 1, 0) !== 100 || qe[1] !== 1'b1 || qe[0] !== 1'b0) begin
            errors++;
            $display("FAIL y0_jump: moved=%b pos=%0d quad_err=%b, expected no move pos=100 quad_err=xx10",
                     seen, get_pos(1, 1, 0), qe);
        end
        repeat (5) tick();
        qe = get_qerr(1);
        checks++;
        if (qe[1] !== 1'b1) begin
            errors++;
            $display("FAIL quad_err_sticky: quad_err=%b, expected bit1=1", qe);
        end
        bus1.recenter[0] = 1'b1;
        tick();
        bus1.recenter[0] = 1'b0;
        model1[0][0] = 100;
        qe = get_qerr(1);
        checks++;
        if (get_pos(1, 0, 0) !== 100 || get_pos(1, 1, 0) !== 100 || qe[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL x4_recenter: pos=%0d/%0d quad_err=%b, expected 100/100 quad_err=xx00",
                     get_pos(1, 0, 0), get_pos(1, 1, 0), qe);
        end
        // Player 1 X and Y steps land in the same cycle
        q_exp.push_back(model1[0][1] + 4);
        q_exp.push_back(model1[1][1] + 4);
        set_pin(1, 0, 1, 1'b1, 1'b1);
        set_pin(1, 1, 1, 1'b1, 1'b1);
        seen = 1'b0;
        lat  = 0;
        ox   = 0;
        oy   = 0;
        for (int k = 1; k <= c_win; k++) begin
            tick();
            if (!seen && get_moved(1, 1)) begin
                seen = 1'b1;
                lat  = k;
                ox   = get_pos(1, 0, 1);
                oy   = get_pos(1, 1, 1);
            end
        end
        e  = q_exp.pop_front();
        ey = q_exp.pop_front();
        checks++;
        if (!seen || ox !== e || oy !== ey || lat !== c_lat) begin
            errors++;
            $display("FAIL xy_same_cycle: seen=%b pos=%0d/%0d lat=%0d, expected %0d/%0d lat=%0d",
                     seen, ox, oy, lat, e, ey, c_lat);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_x1_latency();
        test_glitch();
        test_saturation();
        test_freeze();
        test_recenter_priority();
        test_quad();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
